// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller for the Simple CPU v1. It reads one
// instruction word from instruction memory at the current PC using a
// req/ack handshake. The word is held in the instruction register (ir) until
// the decoder accepts it through a valid/ready handshake. On that handshake
// the controller pulses the PC load enable for one cycle, with the next
// address set to either PC+1 or the branch target supplied by execute.
// A memory that never acknowledges drives the controller into a terminal
// error state, and a sticky error flag is raised. Only clr leaves that state.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   clr        in   1   asynchronous active-low reset
//   pc_adrs    in   8   current program counter value
//   nxt_adrs   out  8   next PC value (PC+1, or br_target on a taken branch)
//   en_pc      out  1   PC load enable, one-cycle pulse on the ir handshake
//   mem_req    out  1   instruction memory read request
//   mem_adrs   out  8   read address, always equal to pc_adrs
//   mem_ack    in   1   read complete; mem_rdata valid this cycle
//   mem_rdata  in   DW  instruction read data
//   ir         out  DW  registered fetched instruction
//   ir_valid   out  1   ir holds an instruction not yet consumed
//   ir_ready   in   1   decoder accepts ir
//   br_taken   in   1   consumed instruction redirects fetch
//   br_target  in   8   branch target, used with br_taken
//   fetch_err  out  1   sticky memory-timeout flag
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [7:0]    pc_adrs,
    output logic [7:0]    nxt_adrs,
    output logic          en_pc,
    output logic          mem_req,
    output logic [7:0]    mem_adrs,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          br_taken,
    input  logic [7:0]    br_target,
    output logic          fetch_err
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // The wait counter holds the number of FETCH cycles that have already
    // passed without an ack. A timeout fires when the counter already shows
    // TIMEOUT-1 and the current cycle also has no ack. That cycle is then
    // FETCH cycle number TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   ir_q, ir_d;
    logic            ir_valid_q, ir_valid_d;
    logic            fetch_err_q, fetch_err_d;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
    logic            handshake_s;
    logic [7:0]      pc_inc_s;

    // PC+1 wraps modulo 256. From address 8'hFF it goes to 8'h00.
    assign pc_inc_s    = pc_adrs + 8'd1;
    assign handshake_s = ir_valid_q & ir_ready;

    // The memory is always addressed by the live PC. The PC only loads on
    // en_pc, so pc_adrs stays stable for the whole of a FETCH.
    assign mem_adrs  = pc_adrs;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_START;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        tmo_cnt_d   = tmo_cnt_q;
        mem_req     = 1'b0;
        en_pc       = 1'b0;
        nxt_adrs    = pc_inc_s;

        case (state_q)
            S_START: begin
                // Idle cycle after reset release, then fetch from the reset PC.
                tmo_cnt_d = 8'd0;
                state_d   = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // An ack takes priority over a timeout in the same cycle.
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    tmo_cnt_d  = 8'd0;
                    state_d    = S_VALID;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    fetch_err_d = 1'b1;
                    tmo_cnt_d   = 8'd0;
                    state_d     = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end

            S_VALID: begin
                // The branch inputs only matter on the cycle the decoder
                // takes ir. ir keeps its value after the handshake.
                if (handshake_s) begin
                    en_pc      = 1'b1;
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                    if (br_taken) begin
                        nxt_adrs = br_target;
                    end else begin
                        nxt_adrs = pc_inc_s;
                    end
                end else begin
                    ir_valid_d = ir_valid_q;
                end
            end

            S_ERR: begin
                // Terminal state: only clr leaves it.
                ir_valid_d = 1'b0;
                state_d    = S_ERR;
            end

            default: begin
                ir_valid_d = 1'b0;
                state_d    = S_START;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic       clk;
    logic       clr;
    logic [7:0] pc_adrs;
    logic [7:0] nxt_adrs;
    logic       en_pc;
    logic       mem_req;
    logic [7:0] mem_adrs;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] ir;
    logic       ir_valid;
    logic       ir_ready;
    logic       br_taken;
    logic [7:0] br_target;
    logic       fetch_err;

    fetch_ctrl #(.DW(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .clr       (clr),
        .pc_adrs   (pc_adrs),
        .nxt_adrs  (nxt_adrs),
        .en_pc     (en_pc),
        .mem_req   (mem_req),
        .mem_adrs  (mem_adrs),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [7:0] pc;
        logic       ack;
        logic [7:0] rd;
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       req;
        logic       en;
        logic [7:0] nxt;
        logic [7:0] ir;
        logic       v;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] pc, input logic ack, input logic [7:0] rd,
                                input logic rdy, input logic br, input logic [7:0] tgt,
                                input logic req, input logic en, input logic [7:0] nxt,
                                input logic [7:0] irx, input logic v, input logic err);
        vec_t r;
        r.pc = pc; r.ack = ack; r.rd = rd; r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.req = req; r.en = en; r.nxt = nxt; r.ir = irx; r.v = v; r.err = err;
        return r;
    endfunction

    vec_t tbl [20];

    // ---------------- behavioural PC / memory / decoder model ----------------
    logic [7:0] pc_q;
    int  wait_n, wcnt, stall_n, scnt;
    bit  mem_off;
    logic s_req, s_en, s_v, s_err;
    logic [7:0] s_nxt, s_ir;
    int  req_cnt, en_cnt;
    logic [7:0] fa_q[$];
    logic [7:0] nx_q[$];
    logic [7:0] ir_q[$];

    // One clock cycle: drive at negedge, sample 1ns later, PC loads on posedge.
    task automatic tick();
        pc_adrs = pc_q;
        if (mem_req && !mem_off) begin
            if (wcnt == wait_n) begin
                mem_ack = 1'b1; mem_rdata = pc_q ^ 8'hA5; wcnt = 0;
            end else begin
                mem_ack = 1'b0; wcnt++;
            end
        end else begin
            mem_ack = 1'b0; wcnt = 0;
        end
        if (ir_valid) begin
            if (scnt == stall_n) begin
                ir_ready = 1'b1; scnt = 0;
            end else begin
                ir_ready = 1'b0; scnt++;
            end
        end else begin
            ir_ready = 1'b0; scnt = 0;
        end
        #1;
        s_req = mem_req; s_en = en_pc; s_nxt = nxt_adrs; s_ir = ir; s_v = ir_valid; s_err = fetch_err;
        if (mem_ack && mem_req) fa_q.push_back(mem_adrs);
        if (en_pc) begin
            nx_q.push_back(nxt_adrs);
            ir_q.push_back(ir);
        end
        req_cnt += int'(s_req);
        en_cnt  += int'(s_en);
        @(posedge clk);
        if (s_en) pc_q = s_nxt;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] pc0);
        @(negedge clk);
        clr = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; br_taken = 1'b0; br_target = 8'h00;
        mem_rdata = 8'h00; pc_q = pc0; pc_adrs = pc0; wcnt = 0; scnt = 0;
        req_cnt = 0; en_cnt = 0; s_req = 0; s_en = 0; s_v = 0; s_err = 0;
        fa_q.delete(); nx_q.delete(); ir_q.delete();
        @(negedge clk);
        clr = 1'b1;
    endtask

    int ticks, stall, ir_bad;

    initial begin
        clr = 1'b0; pc_adrs = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        ir_ready = 1'b0; br_taken = 1'b0; br_target = 8'h00;
        pc_q = 8'h00; wait_n = 0; stall_n = 0; mem_off = 0; wcnt = 0; scnt = 0;

        //                pc    ack rd     rdy br tgt     req en nxt    ir     v  err
        tbl[0]  = mk(8'h00, 0, 8'h00, 1, 0, 8'h00,  0, 0, 8'h01, 8'h00, 0, 0);
        tbl[1]  = mk(8'h00, 1, 8'hA5, 1, 1, 8'h77,  1, 0, 8'h01, 8'h00, 0, 0);
        tbl[2]  = mk(8'h00, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h01, 8'hA5, 1, 0);
        tbl[3]  = mk(8'h01, 1, 8'hA4, 1, 0, 8'h00,  1, 0, 8'h02, 8'hA5, 0, 0);
        tbl[4]  = mk(8'h01, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h02, 8'hA4, 1, 0);
        tbl[5]  = mk(8'h02, 1, 8'hA7, 1, 0, 8'h00,  1, 0, 8'h03, 8'hA4, 0, 0);
        tbl[6]  = mk(8'h02, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h03, 8'hA7, 1, 0);
        tbl[7]  = mk(8'h03, 1, 8'hA6, 1, 0, 8'h00,  1, 0, 8'h04, 8'hA7, 0, 0);
        tbl[8]  = mk(8'h03, 1, 8'hFF, 0, 1, 8'h55,  0, 0, 8'h04, 8'hA6, 1, 0);
        tbl[9]  = mk(8'h03, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h04, 8'hA6, 1, 0);
        tbl[10] = mk(8'h04, 0, 8'h00, 1, 0, 8'h00,  1, 0, 8'h05, 8'hA6, 0, 0);
        tbl[11] = mk(8'h04, 1, 8'hA1, 1, 0, 8'h00,  1, 0, 8'h05, 8'hA6, 0, 0);
        tbl[12] = mk(8'h04, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h05, 8'hA1, 1, 0);
        tbl[13] = mk(8'h05, 1, 8'hA0, 1, 0, 8'h00,  1, 0, 8'h06, 8'hA1, 0, 0);
        tbl[14] = mk(8'h05, 0, 8'h00, 1, 1, 8'h40,  0, 1, 8'h40, 8'hA0, 1, 0);
        tbl[15] = mk(8'h40, 1, 8'hE5, 1, 0, 8'h00,  1, 0, 8'h41, 8'hA0, 0, 0);
        tbl[16] = mk(8'h40, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h41, 8'hE5, 1, 0);
        tbl[17] = mk(8'h41, 0, 8'h00, 1, 1, 8'h99,  1, 0, 8'h42, 8'hE5, 0, 0);
        tbl[18] = mk(8'h41, 1, 8'hE4, 1, 0, 8'h00,  1, 0, 8'h42, 8'hE5, 0, 0);
        tbl[19] = mk(8'h41, 0, 8'h00, 1, 0, 8'h00,  0, 1, 8'h42, 8'hE4, 1, 0);

        // Reset values while clr is held low.
        #3;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_en", en_pc, 1'b0);
        chk("rst_nxt", nxt_adrs, 8'h01);
        chk("rst_ir", ir, 8'h00);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_err", fetch_err, 1'b0);
        @(negedge clk);
        clr = 1'b1;

        // Sequential fetch, ignored acks/branches, wait state, branch redirect.
        for (int i = 0; i < 20; i++) begin
            pc_adrs = tbl[i].pc; mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
            ir_ready = tbl[i].rdy; br_taken = tbl[i].br; br_target = tbl[i].tgt;
            #1;
            chk($sformatf("v%0d_req", i), mem_req, tbl[i].req);
            chk($sformatf("v%0d_en", i), en_pc, tbl[i].en);
            chk($sformatf("v%0d_nxt", i), nxt_adrs, tbl[i].nxt);
            chk($sformatf("v%0d_madr", i), mem_adrs, tbl[i].pc);
            chk($sformatf("v%0d_ir", i), ir, tbl[i].ir);
            chk($sformatf("v%0d_valid", i), ir_valid, tbl[i].v);
            chk($sformatf("v%0d_err", i), fetch_err, tbl[i].err);
            @(negedge clk);
        end

        // Wrap-around from 8'hFE at full throughput.
        wait_n = 0; stall_n = 0; mem_off = 0;
        do_reset(8'hFE);
        ticks = 0;
        for (int k = 0; k < 30 && en_cnt < 3; k++) begin tick(); ticks++; end
        chk("wrap_en_cnt", en_cnt, 3);
        chk("wrap_cycles", ticks, 7);
        chk("wrap_nfetch", fa_q.size(), 3);
        if (fa_q.size() == 3 && nx_q.size() == 3) begin
            chk("wrap_fa0", fa_q[0], 8'hFE);
            chk("wrap_fa1", fa_q[1], 8'hFF);
            chk("wrap_fa2", fa_q[2], 8'h00);
            chk("wrap_nx0", nx_q[0], 8'hFF);
            chk("wrap_nx1", nx_q[1], 8'h00);
            chk("wrap_nx2", nx_q[2], 8'h01);
            chk("wrap_ir0", ir_q[0], 8'h5B);
            chk("wrap_ir2", ir_q[2], 8'hA5);
        end

        // Wait states and backpressure: 3 wait cycles, ready low for 4.
        wait_n = 3; stall_n = 4;
        do_reset(8'h10);
        ticks = 0; stall = 0; ir_bad = 0;
        for (int k = 0; k < 40 && en_cnt < 1; k++) begin
            tick(); ticks++;
            if (s_v && !s_en) begin
                stall++;
                if (s_ir !== 8'hB5) ir_bad++;
            end
        end
        chk("bp_req_cycles", req_cnt, 4);
        chk("bp_stall_cycles", stall, 4);
        chk("bp_ir_stable", ir_bad, 0);
        chk("bp_cycles", ticks, 10);
        tick();
        chk("bp_en_once", en_cnt, 1);
        if (nx_q.size() == 1) chk("bp_nxt", nx_q[0], 8'h11);
        else chk("bp_nxt_cnt", nx_q.size(), 1);

        // Timeout with memory never acknowledging.
        wait_n = 0; stall_n = 0; mem_off = 1;
        do_reset(8'h00);
        for (int k = 0; k < 60 && !s_err; k++) tick();
        chk("tmo_err", s_err, 1'b1);
        chk("tmo_req_cycles", req_cnt, 15);
        chk("tmo_req_drop", s_req, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        chk("tmo_req_after", req_cnt, 15);
        chk("tmo_en_after", en_cnt, 0);
        chk("tmo_valid_after", s_v, 1'b0);
        chk("tmo_err_sticky", fetch_err, 1'b1);
        clr = 1'b0;
        #1;
        chk("tmo_clr_err", fetch_err, 1'b0);
        chk("tmo_clr_req", mem_req, 1'b0);
        mem_off = 0;
        do_reset(8'h00);
        for (int k = 0; k < 20 && en_cnt < 1; k++) tick();
        chk("tmo_restart_n", fa_q.size(), 1);
        if (fa_q.size() >= 1) chk("tmo_restart_adr", fa_q[0], 8'h00);
        if (ir_q.size() >= 1) chk("tmo_restart_ir", ir_q[0], 8'hA5);

        // Asynchronous reset while holding a valid instruction.
        stall_n = 10;
        do_reset(8'h00);
        for (int k = 0; k < 20 && !s_v; k++) tick();
        chk("ar_pre_valid", ir_valid, 1'b1);
        chk("ar_pre_ir", ir, 8'hA5);
        #2;
        clr = 1'b0;
        #1;
        chk("ar_valid", ir_valid, 1'b0);
        chk("ar_ir", ir, 8'h00);
        chk("ar_req", mem_req, 1'b0);
        stall_n = 0;
        do_reset(8'h00);
        for (int k = 0; k < 20 && fa_q.size() < 1; k++) tick();
        chk("ar_restart_n", fa_q.size(), 1);
        if (fa_q.size() >= 1) chk("ar_restart_adr", fa_q[0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller for the Simple CPU v1; sits between the program counter and instruction memory. It takes the current PC value, performs a req/ack read of instruction memory, and presents the fetched instruction to the decoder with a valid/ready handshake. It closes the PC loop by driving the next address and the PC load enable: sequential increment, or a branch target supplied by execute.

## Interface
- DW, 8, instruction word width
- TIMEOUT, 15, maximum cycles to wait for mem_ack before flagging an error (1..255)

- clk  in  1  clock, all state updates on rising edge
- clr  in  1  reset, asynchronous, active-low
- pc_adrs  in  8  current program counter value (PC output)
- nxt_adrs  out  8  next address to PC load input
- en_pc  out  1  PC load enable, single-cycle pulse
- mem_req  out  1  instruction memory read request
- mem_adrs  out  8  read address, equals pc_adrs (combinational)
- mem_ack  in  1  memory read complete, mem_rdata valid this cycle
- mem_rdata  in  DW  instruction read data
- ir  out  DW  registered fetched instruction
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decoder accepts ir
- br_taken  in  1  consumed instruction redirects fetch; sampled only on ir handshake
- br_target  in  8  branch target, sampled with br_taken
- fetch_err  out  1  sticky: memory timeout occurred

## Operation
- States: START, FETCH, VALID, ERR.
- Reset (clr=0, async): state=START, ir=0, ir_valid=0, fetch_err=0, timeout counter=0. Combinational outputs at reset: mem_req=0, en_pc=0, nxt_adrs=pc_adrs+1.
- START: one cycle after clr deassertion; no request; -> FETCH.
- FETCH: mem_req=1, mem_adrs=pc_adrs. Counter increments each cycle without mem_ack.
  - mem_ack=1: ir<=mem_rdata, ir_valid<=1, counter<=0, -> VALID. Ack in the first FETCH cycle (zero-wait memory) is legal.
  - Counter reaches TIMEOUT with no ack: fetch_err<=1, mem_req drops next cycle, -> ERR.
- VALID: mem_req=0. Handshake = ir_valid & ir_ready.
  - On handshake: en_pc=1 that cycle; nxt_adrs = br_taken ? br_target : pc_adrs+1. ir_valid<=0, -> FETCH. ir keeps its last value.
  - Without handshake: ir and ir_valid hold, en_pc=0.
- ERR: terminal. mem_req=0, en_pc=0, ir_valid=0. Exit only via clr.
- Address arithmetic: 8-bit modulo; pc_adrs=8'hFF increments to 8'h00. br_target is used unmodified.
- br_taken and br_target are ignored outside the handshake cycle.
- en_pc is never asserted outside VALID and never asserted for more than one cycle per instruction.
- mem_ack outside FETCH is ignored: no state change, ir unchanged.
- pc_adrs is stable throughout FETCH, because the PC only loads on en_pc.

## Timing
- PC loads nxt_adrs on the edge ending the handshake cycle. FETCH in the next cycle therefore sees the updated pc_adrs on mem_adrs; no bubble cycle is needed.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ack, then VALID with ir_ready=1).
- Fetch latency: ir_valid rises 1 cycle after the mem_ack cycle.
- First request: mem_req rises in the 2nd cycle after clr deassertion, at address 8'h00.
- Timeout: with no ack, fetch_err rises after TIMEOUT FETCH cycles (edge ending FETCH cycle TIMEOUT).
- Reset mid-operation: clr low in any state immediately clears ir_valid, mem_req and fetch_err. A pending memory ack is discarded.

## Test plan
- Sequential fetch: memory acks in 1 cycle with rdata = address xor 8'hA5, ir_ready=1 -> ir sequence 8'hA5, 8'hA4, 8'hA7, ...; en_pc pulses every 2nd cycle; nxt_adrs = 1, 2, 3, ...
- Wrap-around: PC preloaded to 8'hFE, run 3 instructions -> fetch addresses 8'hFE, 8'hFF, 8'h00; nxt_adrs 8'hFF, 8'h00, 8'h01.
- Branch: br_taken=1, br_target=8'h40 on handshake of the instruction at 8'h05 -> en_pc with nxt_adrs=8'h40; next mem_adrs=8'h40. br_taken=1 held while ir_valid=0 -> no effect.
- Backpressure and wait states: mem_ack after 3 cycles, ir_ready low 4 cycles -> mem_req high exactly 4 cycles; ir/ir_valid stable while stalled; exactly one en_pc per instruction.
- Timeout: TIMEOUT=15, mem_ack tied 0 -> fetch_err=1 after 15 FETCH cycles; mem_req=0 and no en_pc afterwards. Pulse clr -> fetch_err=0 and a normal fetch at 8'h00.
- Async reset mid-fetch: assert clr while in VALID with ir_valid=1 -> ir_valid=0, ir=0 immediately without a clock edge; restart fetches address 8'h00.
